// File: rtl/process_features_udiv_17ns_10ns_17_seq_if.sv
// Operand/result handshake bundle for the sequential unsigned divider.
//   in_valid/in_ready : operand pair handshake (din0 dividend, din1 divisor)
//   out_valid/out_ready : result handshake (quot, rem, div_by_zero)
// master modport: the side that supplies operands and consumes results.
// slave modport : the divider itself.
interface process_features_udiv_17ns_10ns_17_seq_if #(
  parameter int unsigned din0_WIDTH = 17,
  parameter int unsigned din1_WIDTH = 10,
  parameter int unsigned dout_WIDTH = 17
);
  logic                  in_valid;
  logic                  in_ready;
  logic [din0_WIDTH-1:0] din0;
  logic [din1_WIDTH-1:0] din1;
  logic                  out_valid;
  logic                  out_ready;
  logic [dout_WIDTH-1:0] quot;
  logic [din1_WIDTH-1:0] rem;
  logic                  div_by_zero;

  modport master (
    output in_valid, din0, din1, out_ready,
    input  in_ready, out_valid, quot, rem, div_by_zero
  );

  modport slave (
    input  in_valid, din0, din1, out_ready,
    output in_ready, out_valid, quot, rem, div_by_zero
  );
endinterface

// File: rtl/process_features_udiv_17ns_10ns_17_seq.sv
// Sequential unsigned restoring divider: din0 / din1 -> quot, rem.
// Resolves one quotient bit per clock, so a result appears din0_WIDTH cycles
// after the operands are accepted.
// Ports:
//   ap_clk  : clock, rising edge
//   ap_rst  : synchronous active-high reset, discards any operation in flight
//   bus     : slave side of the operand/result handshake interface
//             (in_valid/in_ready/din0/din1 in, out_valid/out_ready/quot/rem/div_by_zero out)
// A zero divisor yields the natural restoring result: quot all ones,
// rem = din0 mod 2^din1_WIDTH, div_by_zero set.
module process_features_udiv_17ns_10ns_17_seq #(
  parameter int unsigned ID         = 1,
  parameter int unsigned din0_WIDTH = 17,
  parameter int unsigned din1_WIDTH = 10,
  parameter int unsigned dout_WIDTH = 17
) (
  input logic                                ap_clk,
  input logic                                ap_rst,
  process_features_udiv_17ns_10ns_17_seq_if.slave bus
);

  localparam int unsigned N    = din0_WIDTH;
  localparam int unsigned M    = din1_WIDTH;
  localparam int unsigned CntW = $clog2(N + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e              state_q;
  logic [dout_WIDTH-1:0] q_q;
  logic [M-1:0]        r_q;
  logic [M-1:0]        d_q;
  logic [CntW-1:0]     cnt_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic                dbz_q;

  logic [M:0]          t;
  logic                ge;
  logic [M:0]          r_next;

  // Instance tag only; kept visible so it survives in the netlist hierarchy.
  logic unused_id;
  assign unused_id = ^ID;

  // One restoring step, M+1 bits wide so the trial subtraction never wraps.
  always_comb begin
    t      = {r_q, q_q[N-1]};
    ge     = (t >= {1'b0, d_q});
    r_next = ge ? (t - {1'b0, d_q}) : t;
  end

  // r_next < d_q always fits in M bits for a non-zero divisor; with d_q == 0
  // truncating to M bits leaves exactly din0 mod 2^M after the last step.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q     <= StIdle;
      q_q         <= '0;
      r_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            q_q        <= bus.din0;
            d_q        <= bus.din1;
            r_q        <= '0;
            cnt_q      <= '0;
            dbz_q      <= (bus.din1 == '0);
            in_ready_q <= 1'b0;
            state_q    <= StCalc;
          end
        end
        StCalc: begin
          q_q   <= {q_q[N-2:0], ge};
          r_q   <= r_next[M-1:0];
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntW'(N - 1)) begin
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q     <= StIdle;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.quot        = q_q;
  assign bus.rem         = r_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_process_features_udiv_17ns_10ns_17_seq.sv
module tb_process_features_udiv_17ns_10ns_17_seq;

  logic clk;
  logic rst;

  process_features_udiv_17ns_10ns_17_seq_if bus ();

  process_features_udiv_17ns_10ns_17_seq dut (
    .ap_clk (clk),
    .ap_rst (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [16:0] a;
    logic [9:0]  b;
    logic [16:0] q;
    logic [9:0]  r;
    logic        z;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   rdy_mode = 0;  // 0: out_ready high, 1: low, 2: random

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: plain integer division; zero divisor gives all-ones quotient and
  // the low divisor-width bits of the dividend as remainder.
  function automatic exp_t ref_div(input logic [16:0] a, input logic [9:0] b);
    exp_t e;
    e.a = a;
    e.b = b;
    if (b == 0) begin
      e.q = 17'h1FFFF;
      e.r = a[9:0];
      e.z = 1'b1;
    end else begin
      e.q = a / 17'(b);
      e.r = 10'(a % 17'(b));
      e.z = 1'b0;
    end
    return e;
  endfunction

  // out_ready driver
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0)      bus.out_ready = 1'b1;
      else if (rdy_mode == 1) bus.out_ready = 1'b0;
      else                    bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result got=%0h exp=none", bus.quot);
        end else begin
          e = sb.pop_front();
          check("quot", 32'(bus.quot), 32'(e.q));
          check("rem", 32'(bus.rem), 32'(e.r));
          check("div_by_zero", 32'(bus.div_by_zero), 32'(e.z));
          if (e.b != 0) begin
            check("identity", 32'(bus.quot) * 32'(e.b) + 32'(bus.rem), 32'(e.a));
            check("rem_lt_div", 32'(bus.rem < e.b), 32'd1);
          end
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Present an operand pair and hold it until accepted.
  task automatic issue(input logic [16:0] a, input logic [9:0] b, input bit push);
    int waited;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.din0     = a;
    bus.din1     = b;
    waited = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      waited++;
      if (waited > 200) begin
        check("accept_timeout", 32'(waited), 32'd0);
        break;
      end
    end
    @(posedge clk);
    if (push) sb.push_back(ref_div(a, b));
    #1;
    bus.in_valid = 1'b0;
    bus.din0     = 17'($urandom);  // must be ignored while busy
    bus.din1     = 10'($urandom);
  endtask

  // Count edges from acceptance until out_valid is seen.
  task automatic wait_out(output int lat);
    lat = 0;
    forever begin
      @(negedge clk);
      if (bus.out_valid) break;
      lat++;
      if (lat > 100) begin
        check("out_valid_timeout", 32'(lat), 32'd17);
        break;
      end
    end
  endtask

  task automatic directed(input string name, input logic [16:0] a, input logic [9:0] b,
                          input logic [16:0] eq, input logic [9:0] er, input logic ez);
    int lat;
    issue(a, b, 1'b1);
    wait_out(lat);
    check({name, "_latency"}, 32'(lat), 32'd17);
    check({name, "_quot"}, 32'(bus.quot), 32'(eq));
    check({name, "_rem"}, 32'(bus.rem), 32'(er));
    check({name, "_dbz"}, 32'(bus.div_by_zero), 32'(ez));
  endtask

  initial begin
    int   lat;
    exp_t e;
    logic [16:0] a;
    logic [9:0]  b;

    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.din0     = '0;
    bus.din1     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_quot", 32'(bus.quot), 32'd0);
    check("rst_rem", 32'(bus.rem), 32'd0);
    check("rst_dbz", 32'(bus.div_by_zero), 32'd0);
    rst = 1'b0;

    directed("d100000_300", 17'd100000, 10'd300, 17'd333, 10'd100, 1'b0);
    directed("d131071_1", 17'd131071, 10'd1, 17'd131071, 10'd0, 1'b0);
    directed("d5_10", 17'd5, 10'd10, 17'd0, 10'd5, 1'b0);
    directed("d1234_0", 17'd1234, 10'd0, 17'h1FFFF, 10'd210, 1'b1);

    // Backpressure: result must hold while out_ready is low.
    rdy_mode = 1;
    a = 17'd50000;
    b = 10'd77;
    e = ref_div(a, b);
    issue(a, b, 1'b1);
    wait_out(lat);
    check("bp_latency", 32'(lat), 32'd17);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_quot", 32'(bus.quot), 32'(e.q));
      check("bp_rem", 32'(bus.rem), 32'(e.r));
    end
    rdy_mode = 0;
    @(posedge clk);  // out_ready rises after this edge
    @(posedge clk);  // handshake
    @(negedge clk);
    check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    check("bp_release_out_valid", 32'(bus.out_valid), 32'd0);

    // Reset in the middle of a calculation discards it.
    issue(17'd1000, 10'd3, 1'b0);
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    directed("d999_7", 17'd999, 10'd7, 17'd142, 10'd5, 1'b0);

    // Random soak with random gaps and random backpressure.
    rdy_mode = 2;
    for (int i = 0; i < 1500; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      a = 17'($urandom);
      b = 10'($urandom);
      if ($urandom_range(0, 15) == 0) b = '0;
      if ($urandom_range(0, 15) == 0) b = 10'd1;
      issue(a, b, 1'b1);
    end
    rdy_mode = 0;
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    check("drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
